// File: rtl/id_ex_cond_stage.sv
// Decode->execute pipeline register with NZCV flag
// register and condition-gated write controls.
module id_ex_cond_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             PCSrcD,
  input  logic             RegWriteD,
  input  logic             MemToRegD,
  input  logic             MemWriteD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic             NoWriteD,
  input  logic [3:0]       ALUControlD,
  input  logic [1:0]       FlagWriteD,
  input  logic [3:0]       CondD,
  input  logic [3:0]       WA3D,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] ExtImmD,
  input  logic [3:0]       ALUFlagsE,
  output logic             PCSrcE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             BranchTakenE,
  output logic             MemToRegE,
  output logic             ALUSrcE,
  output logic [3:0]       ALUControlE,
  output logic [3:0]       WA3E,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [WIDTH-1:0] ExtImmE,
  output logic             CondExE,
  output logic [3:0]       FlagsE
);

  typedef struct packed {
    logic             pcsrc;
    logic             regwrite;
    logic             memtoreg;
    logic             memwrite;
    logic             branch;
    logic             alusrc;
    logic             nowrite;
    logic [3:0]       aluctl;
    logic [1:0]       flagwrite;
    logic [3:0]       cond;
    logic [3:0]       wa3;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
  } id_ex_t;

  localparam logic [3:0] COND_AL = 4'b1110;

  id_ex_t     w_d;
  id_ex_t     w_bubble;
  id_ex_t     r_e;
  logic [3:0] r_flags;
  logic       w_n, w_z, w_c, w_v;
  logic       w_condex;

  // Pack decode-side fields and build the bubble word.
  always_comb begin
    w_d           = '0;
    w_d.pcsrc     = PCSrcD;
    w_d.regwrite  = RegWriteD;
    w_d.memtoreg  = MemToRegD;
    w_d.memwrite  = MemWriteD;
    w_d.branch    = BranchD;
    w_d.alusrc    = ALUSrcD;
    w_d.nowrite   = NoWriteD;
    w_d.aluctl    = ALUControlD;
    w_d.flagwrite = FlagWriteD;
    w_d.cond      = CondD;
    w_d.wa3       = WA3D;
    w_d.rd1       = RD1D;
    w_d.rd2       = RD2D;
    w_d.imm       = ExtImmD;
    w_bubble      = '0;
    w_bubble.cond = COND_AL;
  end

  // Stage register: reset/flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset || FlushE)
      r_e <= w_bubble;
    else if (!StallE)
      r_e <= w_d;
  end

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  // Condition check against the registered flags.
  always_comb begin
    w_condex = 1'b0;
    case (r_e.cond)
      4'b0000: w_condex = w_z;
      4'b0001: w_condex = !w_z;
      4'b0010: w_condex = w_c;
      4'b0011: w_condex = !w_c;
      4'b0100: w_condex = w_n;
      4'b0101: w_condex = !w_n;
      4'b0110: w_condex = w_v;
      4'b0111: w_condex = !w_v;
      4'b1000: w_condex = w_c && !w_z;
      4'b1001: w_condex = !w_c || w_z;
      4'b1010: w_condex = (w_n == w_v);
      4'b1011: w_condex = (w_n != w_v);
      4'b1100: w_condex = !w_z && (w_n == w_v);
      4'b1101: w_condex = w_z || (w_n != w_v);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  // NZCV update; a held instruction never rewrites flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (w_condex && !StallE) begin
      if (r_e.flagwrite[1])
        r_flags[3:2] <= ALUFlagsE[3:2];
      if (r_e.flagwrite[0])
        r_flags[1:0] <= ALUFlagsE[1:0];
    end
  end

  assign CondExE      = w_condex;
  assign FlagsE       = r_flags;
  assign PCSrcE       = r_e.pcsrc && w_condex;
  assign RegWriteE    = r_e.regwrite && w_condex
                        && !r_e.nowrite;
  assign MemWriteE    = r_e.memwrite && w_condex;
  assign BranchTakenE = r_e.branch && w_condex;
  assign MemToRegE    = r_e.memtoreg;
  assign ALUSrcE      = r_e.alusrc;
  assign ALUControlE  = r_e.aluctl;
  assign WA3E         = r_e.wa3;
  assign RD1E         = r_e.rd1;
  assign RD2E         = r_e.rd2;
  assign ExtImmE      = r_e.imm;

endmodule
